// File: rtl/branch_tag_resolver.sv
// Orders out-of-order branch outcomes and retires them oldest-first as hit/miss recovery pulses.
// Retire outputs are combinational from the head entry; a resolution shows one cycle later; excess allocs are dropped and flag err.
module branch_tag_resolver #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int PC_W  = 32
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             enable,
    input  logic             alloc_valid1,
    input  logic [TAG_W-1:0] alloc_tag1,
    input  logic             alloc_valid2,
    input  logic [TAG_W-1:0] alloc_tag2,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_miss,
    input  logic [PC_W-1:0]  res_target,
    output logic             predict_hit,
    output logic             predict_miss,
    output logic [TAG_W-1:0] tag_fix,
    output logic [TAG_W-1:0] kill_mask,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [2:0]       count,
    output logic             full,
    output logic             err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_res;
    logic [DEPTH-1:0] ent_miss;
    logic [TAG_W-1:0] ent_tag [DEPTH];
    logic [PC_W-1:0]  ent_tgt [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [2:0]       cnt;
    logic             err_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic             retire_hit;
    logic             retire_miss;
    logic [TAG_W-1:0] kill_all;
    logic [2:0]       free_slots;
    logic             req1, req2, acc1, acc2, drop;
    logic [PTR_W-1:0] tail2, tail_nxt;
    logic             match_found;
    logic [PTR_W-1:0] match_idx;
    logic             res_ok, res_bad;

    assign retire_hit  = ent_vld[head] & ent_res[head] & ~ent_miss[head];
    assign retire_miss = ent_vld[head] & ent_res[head] &  ent_miss[head];

    // Valid entries are contiguous from head, so the OR of all of them is head plus every younger one.
    always_comb begin
        kill_all = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) kill_all = kill_all | ent_tag[i];
        end
    end

    assign predict_hit  = retire_hit;
    assign predict_miss = retire_miss;
    assign tag_fix      = retire_miss ? {ent_tag[head][0], ent_tag[head][TAG_W-1:1]} : '0;
    assign kill_mask    = retire_miss ? kill_all : '0;
    assign redirect_pc  = retire_miss ? ent_tgt[head] : '0;
    assign count        = cnt;
    assign full         = (cnt == DEPTH_C);
    assign err          = err_q;

    // Space freed by a retiring head is usable by this cycle's allocs.
    assign free_slots = DEPTH_C - cnt + {2'b00, retire_hit};
    assign req1       = enable & alloc_valid1;
    assign req2       = enable & alloc_valid2;
    assign acc1       = req1 & ~retire_miss & (free_slots != 3'd0);
    assign acc2       = req2 & ~retire_miss & (free_slots > {2'b00, acc1});
    assign drop       = ~retire_miss & ((req1 & ~acc1) | (req2 & ~acc2));
    assign tail2      = acc1 ? ptr_inc(tail) : tail;
    assign tail_nxt   = acc2 ? ptr_inc(tail2) : tail2;

    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_tag[i] == res_tag)) begin
                match_found = 1'b1;
                match_idx   = PTR_W'(i);
            end
        end
    end

    assign res_ok  = res_valid & ~retire_miss & match_found & ~ent_res[match_idx];
    assign res_bad = res_valid & ~retire_miss & ~res_ok;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            ent_vld  <= '0;
            ent_res  <= '0;
            ent_miss <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_tag[i] <= '0;
                ent_tgt[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (retire_miss) begin
                ent_vld <= '0;
                head    <= '0;
                tail    <= '0;
                cnt     <= '0;
            end else begin
                if (retire_hit) begin
                    ent_vld[head] <= 1'b0;
                    head          <= ptr_inc(head);
                end
                if (res_ok) begin
                    ent_res[match_idx]  <= 1'b1;
                    ent_miss[match_idx] <= res_miss;
                    ent_tgt[match_idx]  <= res_target;
                end
                // Alloc writes come last so a full queue popping its head can reuse that slot.
                if (acc1) begin
                    ent_vld[tail]  <= 1'b1;
                    ent_tag[tail]  <= alloc_tag1;
                    ent_res[tail]  <= 1'b0;
                    ent_miss[tail] <= 1'b0;
                end
                if (acc2) begin
                    ent_vld[tail2]  <= 1'b1;
                    ent_tag[tail2]  <= alloc_tag2;
                    ent_res[tail2]  <= 1'b0;
                    ent_miss[tail2] <= 1'b0;
                end
                tail <= tail_nxt;
                cnt  <= cnt + 3'(acc1) + 3'(acc2) - 3'(retire_hit);
            end
            if (drop || res_bad) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_tag_resolver.sv
// Table-driven bench for branch_tag_resolver with a scoreboard queue for retire pulses.
module tb_branch_tag_resolver;
    logic        i_clk = 1'b0;
    logic        i_resetn;
    logic        enable, alloc_valid1, alloc_valid2, res_valid, res_miss;
    logic [4:0]  alloc_tag1, alloc_tag2, res_tag;
    logic [31:0] res_target;
    logic        predict_hit, predict_miss, full, err;
    logic [4:0]  tag_fix, kill_mask;
    logic [31:0] redirect_pc;
    logic [2:0]  count;

    branch_tag_resolver #(.DEPTH(4), .TAG_W(5), .PC_W(32)) dut (
        .i_clk(i_clk), .i_resetn(i_resetn), .enable(enable),
        .alloc_valid1(alloc_valid1), .alloc_tag1(alloc_tag1),
        .alloc_valid2(alloc_valid2), .alloc_tag2(alloc_tag2),
        .res_valid(res_valid), .res_tag(res_tag), .res_miss(res_miss), .res_target(res_target),
        .predict_hit(predict_hit), .predict_miss(predict_miss), .tag_fix(tag_fix),
        .kill_mask(kill_mask), .redirect_pc(redirect_pc), .count(count), .full(full), .err(err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        en, a1;
        logic [4:0]  t1;
        logic        a2;
        logic [4:0]  t2;
        logic        rv;
        logic [4:0]  rt;
        logic        rm;
        logic [31:0] rpc;
        logic        e_hit, e_miss;
        logic [4:0]  e_fix, e_kill;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic        e_full, e_err;
    } vec_t;

    typedef struct {
        logic        hit, miss;
        logic [4:0]  fix, kill;
        logic [31:0] pc;
    } exp_t;

    vec_t tv [31];
    exp_t sb [$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic zero_inputs();
        enable = 0; alloc_valid1 = 0; alloc_tag1 = 0; alloc_valid2 = 0; alloc_tag2 = 0;
        res_valid = 0; res_tag = 0; res_miss = 0; res_target = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_hit"}, predict_hit, 0);
        chk({tag, "_miss"}, predict_miss, 0);
        chk({tag, "_fix"}, tag_fix, 0);
        chk({tag, "_kill"}, kill_mask, 0);
        chk({tag, "_pc"}, redirect_pc, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic step(input vec_t v, input int idx);
        exp_t e;
        @(posedge i_clk); #1;
        enable = v.en; alloc_valid1 = v.a1; alloc_tag1 = v.t1;
        alloc_valid2 = v.a2; alloc_tag2 = v.t2;
        res_valid = v.rv; res_tag = v.rt; res_miss = v.rm; res_target = v.rpc;
        if (v.e_hit || v.e_miss) begin
            e.hit = v.e_hit; e.miss = v.e_miss; e.fix = v.e_fix; e.kill = v.e_kill; e.pc = v.e_pc;
            sb.push_back(e);
        end
        @(negedge i_clk);
        chk($sformatf("v%0d_hit", idx), predict_hit, v.e_hit);
        chk($sformatf("v%0d_miss", idx), predict_miss, v.e_miss);
        chk($sformatf("v%0d_count", idx), count, v.e_cnt);
        chk($sformatf("v%0d_full", idx), full, v.e_full);
        chk($sformatf("v%0d_err", idx), err, v.e_err);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear without a clock edge.
    task automatic mid_reset(input string tag);
        @(posedge i_clk); #3;
        i_resetn = 0;
        zero_inputs();
        #1;
        check_all_zero(tag);
        repeat (2) @(posedge i_clk);
        #3 i_resetn = 1;
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (i_resetn && (predict_hit || predict_miss)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pulse", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_kind", {predict_hit, predict_miss}, {e.hit, e.miss});
                chk("sb_tag_fix", tag_fix, e.fix);
                chk("sb_kill_mask", kill_mask, e.kill);
                chk("sb_redirect_pc", redirect_pc, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          en a1 t1     a2 t2     rv rt     rm rpc           hit miss fix    kill   pc            cnt full err
        tv[0]  = '{0, 0, 5'h00, 0, 5'h00, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd0, 0, 0};
        tv[1]  = '{1, 1, 5'h02, 0, 5'h00, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd0, 0, 0};
        tv[2]  = '{0, 0, 5'h00, 0, 5'h00, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd1, 0, 0};
        tv[3]  = '{0, 0, 5'h00, 0, 5'h00, 1, 5'h02, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd1, 0, 0};
        tv[4]  = '{0, 0, 5'h00, 0, 5'h00, 0, 5'h00, 0, 32'h0,        1, 0, 5'h00, 5'h00, 32'h0,        3'd1, 0, 0};
        tv[5]  = '{0, 1, 5'h10, 0, 5'h00, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd0, 0, 0};
        tv[6]  = '{1, 1, 5'h02, 1, 5'h04, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd0, 0, 0};
        tv[7]  = '{0, 0, 5'h00, 0, 5'h00, 1, 5'h04, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd2, 0, 0};
        tv[8]  = '{0, 0, 5'h00, 0, 5'h00, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd2, 0, 0};
        tv[9]  = '{0, 0, 5'h00, 0, 5'h00, 1, 5'h02, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd2, 0, 0};
        tv[10] = '{0, 0, 5'h00, 0, 5'h00, 0, 5'h00, 0, 32'h0,        1, 0, 5'h00, 5'h00, 32'h0,        3'd2, 0, 0};
        tv[11] = '{0, 0, 5'h00, 0, 5'h00, 0, 5'h00, 0, 32'h0,        1, 0, 5'h00, 5'h00, 32'h0,        3'd1, 0, 0};
        tv[12] = '{0, 0, 5'h00, 0, 5'h00, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd0, 0, 0};
        tv[13] = '{1, 1, 5'h02, 1, 5'h04, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd0, 0, 0};
        tv[14] = '{1, 1, 5'h08, 0, 5'h00, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd2, 0, 0};
        tv[15] = '{0, 0, 5'h00, 0, 5'h00, 1, 5'h02, 1, 32'h0000_1040, 0, 0, 5'h00, 5'h00, 32'h0,        3'd3, 0, 0};
        // Flush cycle with a wrong-path alloc and a late resolution: both ignored, no err.
        tv[16] = '{1, 1, 5'h10, 0, 5'h00, 1, 5'h08, 0, 32'h0,        0, 1, 5'h01, 5'h0E, 32'h0000_1040, 3'd3, 0, 0};
        tv[17] = '{0, 0, 5'h00, 0, 5'h00, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd0, 0, 0};
        tv[18] = '{1, 1, 5'h01, 1, 5'h02, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd0, 0, 0};
        tv[19] = '{1, 1, 5'h04, 1, 5'h08, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd2, 0, 0};
        tv[20] = '{1, 1, 5'h10, 1, 5'h01, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd4, 1, 0};
        tv[21] = '{0, 0, 5'h00, 0, 5'h00, 1, 5'h01, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd4, 1, 1};
        tv[22] = '{1, 1, 5'h10, 0, 5'h00, 0, 5'h00, 0, 32'h0,        1, 0, 5'h00, 5'h00, 32'h0,        3'd4, 1, 1};
        tv[23] = '{0, 0, 5'h00, 0, 5'h00, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd4, 1, 1};
        tv[24] = '{0, 0, 5'h00, 0, 5'h00, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd0, 0, 0};
        tv[25] = '{1, 1, 5'h02, 1, 5'h04, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd0, 0, 0};
        tv[26] = '{1, 1, 5'h08, 0, 5'h00, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd2, 0, 0};
        tv[27] = '{0, 0, 5'h00, 0, 5'h00, 1, 5'h10, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd3, 0, 0};
        tv[28] = '{0, 0, 5'h00, 0, 5'h00, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd3, 0, 1};
        tv[29] = '{0, 0, 5'h00, 0, 5'h00, 1, 5'h02, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd0, 0, 0};
        tv[30] = '{0, 0, 5'h00, 0, 5'h00, 0, 5'h00, 0, 32'h0,        0, 0, 5'h00, 5'h00, 32'h0,        3'd0, 0, 1};

        zero_inputs();
        i_resetn = 0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge i_clk);
        #3 i_resetn = 1;

        for (int i = 0; i <= 23; i++) step(tv[i], i);
        mid_reset("rst_full");
        for (int i = 24; i <= 28; i++) step(tv[i], i);
        mid_reset("rst_pending3");
        for (int i = 29; i <= 30; i++) step(tv[i], i);

        @(negedge i_clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
